// File: rtl/qq_host_port.sv
// qq_host_port: buffers host enqueue/dequeue commands and issues them one at a time to the QuickQ control FSM.
// Define QQ_HOST_STATS_EN to add saturating per-status response counters (stat_ok/stat_rej/stat_tmo).
module qq_host_port #(
    parameter int unsigned KEY_W     = 32,
    parameter int unsigned CMD_DEPTH = 4,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_op,
    input  logic [KEY_W-1:0] cmd_key,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [KEY_W-1:0] rsp_key,
    output logic [1:0]       rsp_status,
    output logic             enq,
    output logic             deq,
    output logic [KEY_W-1:0] enq_key,
    input  logic             done,
    input  logic [KEY_W-1:0] deq_key,
    input  logic             full,
    input  logic             empty,
    output logic             busy
`ifdef QQ_HOST_STATS_EN
    ,
    output logic [15:0]      stat_ok,
    output logic [15:0]      stat_rej,
    output logic [15:0]      stat_tmo
`endif
);

    localparam int unsigned PTR_W = $clog2(CMD_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TMO_W = 16;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_FULL    = 2'b01;
    localparam logic [1:0] ST_EMPTY   = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e             state_q, state_d;
    logic [KEY_W:0]     mem_q [CMD_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               op_q, op_d;
    logic [KEY_W-1:0]   enq_key_q, enq_key_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [KEY_W-1:0]   rsp_key_q, rsp_key_d;
    logic [1:0]         rsp_status_q, rsp_status_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               busy_q, busy_d;
    logic               push, pop;
    logic [KEY_W:0]     head;

    assign head = mem_q[rd_ptr_q];
    assign push = cmd_valid && cmd_ready_q;
    // The head leaves the FIFO in its single ISSUE cycle, whatever the outcome.
    assign pop  = (state_q == ISSUE);

    // Requests depend on full/empty sampled in the ISSUE cycle itself.
    assign enq = pop && !op_q && !full;
    assign deq = pop &&  op_q && !empty;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q + PTR_W'(push);
        rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
        count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
        tmo_d        = tmo_q;
        op_d         = op_q;
        enq_key_d    = enq_key_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_key_d    = rsp_key_q;
        rsp_status_d = rsp_status_q;
        unique case (state_q)
            IDLE: begin
                if (count_q != '0) state_d = ISSUE;
            end
            ISSUE: begin
                if (!op_q && full) begin
                    state_d      = RESP;
                    rsp_valid_d  = 1'b1;
                    rsp_key_d    = '0;
                    rsp_status_d = ST_FULL;
                end else if (op_q && empty) begin
                    state_d      = RESP;
                    rsp_valid_d  = 1'b1;
                    rsp_key_d    = '0;
                    rsp_status_d = ST_EMPTY;
                end else begin
                    state_d = WAIT;
                    tmo_d   = '0;
                end
            end
            WAIT: begin
                if (done) begin
                    state_d      = RESP;
                    rsp_valid_d  = 1'b1;
                    rsp_key_d    = op_q ? deq_key : '0;
                    rsp_status_d = ST_OK;
                end else if (tmo_q == TMO_W'(TIMEOUT)) begin
                    state_d      = RESP;
                    rsp_valid_d  = 1'b1;
                    rsp_key_d    = '0;
                    rsp_status_d = ST_TIMEOUT;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = (count_q != '0) ? ISSUE : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Latch the head command on entry to ISSUE so enq_key is valid alongside the pulse.
        if (state_d == ISSUE && state_q != ISSUE) begin
            op_d = head[KEY_W];
            if (!head[KEY_W]) enq_key_d = head[KEY_W-1:0];
        end
        cmd_ready_d = (count_d != CNT_W'(CMD_DEPTH)) || (state_d == ISSUE);
        busy_d      = (state_d != IDLE) || (count_d != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            tmo_q        <= '0;
            op_q         <= 1'b0;
            enq_key_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_key_q    <= '0;
            rsp_status_q <= '0;
            cmd_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            tmo_q        <= tmo_d;
            op_q         <= op_d;
            enq_key_q    <= enq_key_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_key_q    <= rsp_key_d;
            rsp_status_q <= rsp_status_d;
            cmd_ready_q  <= cmd_ready_d;
            busy_q       <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {cmd_op, cmd_key};
    end

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_key    = rsp_key_q;
    assign rsp_status = rsp_status_q;
    assign enq_key    = enq_key_q;
    assign busy       = busy_q;

`ifdef QQ_HOST_STATS_EN
    localparam int unsigned STAT_W = 16;

    logic [STAT_W-1:0] stat_ok_q, stat_ok_d, stat_rej_q, stat_rej_d, stat_tmo_q, stat_tmo_d;

    // Saturating counters bumped on each response handshake.
    always_comb begin
        stat_ok_d  = stat_ok_q;
        stat_rej_d = stat_rej_q;
        stat_tmo_d = stat_tmo_q;
        if (rsp_valid_q && rsp_ready) begin
            unique case (rsp_status_q)
                ST_OK:      if (stat_ok_q  != '1) stat_ok_d  = stat_ok_q  + STAT_W'(1);
                ST_TIMEOUT: if (stat_tmo_q != '1) stat_tmo_d = stat_tmo_q + STAT_W'(1);
                default:    if (stat_rej_q != '1) stat_rej_d = stat_rej_q + STAT_W'(1);
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ok_q  <= '0;
            stat_rej_q <= '0;
            stat_tmo_q <= '0;
        end else begin
            stat_ok_q  <= stat_ok_d;
            stat_rej_q <= stat_rej_d;
            stat_tmo_q <= stat_tmo_d;
        end
    end

    assign stat_ok  = stat_ok_q;
    assign stat_rej = stat_rej_q;
    assign stat_tmo = stat_tmo_q;
`endif

endmodule
